// File: rtl/pw_conv_pixel_seq.sv
// pw_conv_pixel_seq: sequencer for one output pixel of a 1x1 (pointwise) convolution.
//
// For each output channel ch the block walks the cin input channels, reading one weight and one
// activation per step from synchronous memories and issuing them to an external MAC. Each MAC
// result is chained into the next issue. It then adds the channel bias, runs the sum through an
// external LeakyReLU and an external requantizer, and emits the INT8 result on a valid/ready
// stream. Every stage advances on the external unit's done strobe, not on a fixed delay. A
// watchdog aborts the pixel if a unit stays silent for WAIT_MAX cycles.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, cfg_cin/cout/scale    pixel launch and its configuration (latched on start in IDLE)
//   w_addr, a_addr, b_addr       memory addresses; mem_rd strobe, data returns the next cycle
//   w_data, a_data, b_data       memory read data
//   mac_*                        MAC drive (valid, operands, accumulator in) and result/done
//   lk_*                         LeakyReLU drive and result/done
//   rq_*                         requantize drive and result/done
//   out_valid/out_ready          result stream; out_data is the INT8 result, out_ch its channel
//   busy, done, err              status: not idle, end-of-pixel pulse, sticky watchdog abort
module pw_conv_pixel_seq #(
   parameter int unsigned MAX_CIN  = 64,
   parameter int unsigned MAX_COUT = 64,
   parameter int unsigned WAIT_MAX = 15,
   localparam int unsigned AddrW   = $clog2(MAX_CIN),
   localparam int unsigned ChW     = $clog2(MAX_COUT),
   localparam int unsigned WAddrW  = AddrW + ChW + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [AddrW:0]      cfg_cin,
   input  logic [ChW:0]        cfg_cout,
   input  logic [15:0]         cfg_scale,
   output logic [WAddrW-1:0]   w_addr,
   output logic [AddrW-1:0]    a_addr,
   output logic [ChW-1:0]      b_addr,
   output logic                mem_rd,
   input  logic [7:0]          w_data,
   input  logic [7:0]          a_data,
   input  logic [31:0]         b_data,
   output logic                mac_valid,
   output logic [7:0]          mac_weight,
   output logic [7:0]          mac_act,
   output logic [31:0]         mac_acc_in,
   input  logic [31:0]         mac_acc_out,
   input  logic                mac_done,
   output logic                lk_valid,
   output logic [31:0]         lk_x,
   input  logic [31:0]         lk_y,
   input  logic                lk_done,
   output logic                rq_valid,
   output logic [31:0]         rq_acc,
   output logic [15:0]         rq_scale,
   input  logic [7:0]          rq_out,
   input  logic                rq_done,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic [ChW-1:0]      out_ch,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned WdW = $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {
      StIdle, StFetch, StIssue, StMwait, StBfetch, StLeaky,
      StLwait, StReq, StRwait, StOut, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [AddrW:0]    cin_q, cin_d;
   logic [ChW:0]      cout_q, cout_d;
   logic [15:0]       scale_q, scale_d;
   logic [ChW:0]      ch_q, ch_d;
   logic [AddrW:0]    i_q, i_d;
   logic [31:0]       acc_q, acc_d;
   logic [31:0]       lky_q, lky_d;
   logic [7:0]        out_data_q, out_data_d;
   logic [ChW-1:0]    out_ch_q, out_ch_d;
   logic              err_q, err_d;
   logic [WdW-1:0]    wd_q, wd_d;
   logic              wd_expired;

   // Last cycle of the wait window: a done strobe here is still accepted.
   assign wd_expired = (wd_q == WdW'(WAIT_MAX - 1));

   always_comb begin
      state_d    = state_q;
      cin_d      = cin_q;
      cout_d     = cout_q;
      scale_d    = scale_q;
      ch_d       = ch_q;
      i_d        = i_q;
      acc_d      = acc_q;
      lky_d      = lky_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      err_d      = err_q;
      wd_d       = '0;
      mem_rd     = 1'b0;
      mac_valid  = 1'b0;
      lk_valid   = 1'b0;
      rq_valid   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               cin_d   = cfg_cin;
               cout_d  = cfg_cout;
               scale_d = cfg_scale;
               err_d   = 1'b0;
               ch_d    = '0;
               i_d     = '0;
               acc_d   = '0;
               if (cfg_cout == '0)     state_d = StDone;
               else if (cfg_cin == '0) state_d = StBfetch;
               else                    state_d = StFetch;
            end
         end
         StFetch: begin
            mem_rd  = 1'b1;
            state_d = StIssue;
         end
         StIssue: begin
            mac_valid = 1'b1;
            state_d   = StMwait;
         end
         StMwait: begin
            if (mac_done) begin
               acc_d   = mac_acc_out;
               i_d     = i_q + (AddrW + 1)'(1);
               state_d = ((i_q + (AddrW + 1)'(1)) == cin_q) ? StBfetch : StFetch;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               wd_d = wd_q + WdW'(1);
            end
         end
         StBfetch: begin
            mem_rd  = 1'b1;
            state_d = StLeaky;
         end
         StLeaky: begin
            lk_valid = 1'b1;
            state_d  = StLwait;
         end
         StLwait: begin
            if (lk_done) begin
               lky_d   = lk_y;
               state_d = StReq;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               wd_d = wd_q + WdW'(1);
            end
         end
         StReq: begin
            rq_valid = 1'b1;
            state_d  = StRwait;
         end
         StRwait: begin
            if (rq_done) begin
               out_data_d = rq_out;
               out_ch_d   = ch_q[ChW-1:0];
               state_d    = StOut;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               wd_d = wd_q + WdW'(1);
            end
         end
         StOut: begin
            if (out_ready) begin
               ch_d  = ch_q + (ChW + 1)'(1);
               i_d   = '0;
               acc_d = '0;
               if ((ch_q + (ChW + 1)'(1)) == cout_q) state_d = StDone;
               else if (cin_q == '0)                 state_d = StBfetch;
               else                                  state_d = StFetch;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cin_q      <= '0;
         cout_q     <= '0;
         scale_q    <= '0;
         ch_q       <= '0;
         i_q        <= '0;
         acc_q      <= '0;
         lky_q      <= '0;
         out_data_q <= '0;
         out_ch_q   <= '0;
         err_q      <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         cin_q      <= cin_d;
         cout_q     <= cout_d;
         scale_q    <= scale_d;
         ch_q       <= ch_d;
         i_q        <= i_d;
         acc_q      <= acc_d;
         lky_q      <= lky_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         err_q      <= err_d;
         wd_q       <= wd_d;
      end
   end

   // Operand and address buses are zero outside the cycle that uses them, so a reset or an idle
   // block presents an all-zero interface.
   assign w_addr     = (state_q == StFetch)
                       ? (WAddrW'(ch_q) * WAddrW'(cin_q) + WAddrW'(i_q)) : '0;
   assign a_addr     = (state_q == StFetch)  ? i_q[AddrW-1:0] : '0;
   assign b_addr     = (state_q == StBfetch) ? ch_q[ChW-1:0]  : '0;
   assign mac_weight = (state_q == StIssue)  ? w_data : '0;
   assign mac_act    = (state_q == StIssue)  ? a_data : '0;
   assign mac_acc_in = (state_q == StIssue)  ? acc_q  : '0;
   assign lk_x       = (state_q == StLeaky)  ? (acc_q + b_data) : '0;
   assign rq_acc     = (state_q == StReq)    ? lky_q   : '0;
   assign rq_scale   = (state_q == StReq)    ? scale_q : '0;
   assign out_valid  = (state_q == StOut);
   assign out_data   = out_data_q;
   assign out_ch     = out_ch_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign err        = err_q;

endmodule

// File: tb/tb_pw_conv_pixel_seq.sv
// Bench for pw_conv_pixel_seq: synchronous memory model, stub MAC / LeakyReLU / requantize
// units with random latency, and a reference that computes each channel's INT8 result directly
// from the memory contents.
module tb_pw_conv_pixel_seq;

   localparam int WaitMax = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  cfg_cin = '0;
   logic [6:0]  cfg_cout = '0;
   logic [15:0] cfg_scale = '0;
   logic [12:0] w_addr;
   logic [5:0]  a_addr, b_addr;
   logic        mem_rd;
   logic [7:0]  w_data, a_data;
   logic [31:0] b_data;
   logic        mac_valid;
   logic [7:0]  mac_weight, mac_act;
   logic [31:0] mac_acc_in, mac_acc_out;
   logic        mac_done;
   logic        lk_valid;
   logic [31:0] lk_x, lk_y;
   logic        lk_done;
   logic        rq_valid;
   logic [31:0] rq_acc;
   logic [15:0] rq_scale;
   logic [7:0]  rq_out;
   logic        rq_done;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic [5:0]  out_ch;
   logic        busy, done, err;

   always #5 clk = ~clk;

   pw_conv_pixel_seq #(.MAX_CIN(64), .MAX_COUT(64), .WAIT_MAX(WaitMax)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_cin(cfg_cin), .cfg_cout(cfg_cout), .cfg_scale(cfg_scale),
      .w_addr(w_addr), .a_addr(a_addr), .b_addr(b_addr), .mem_rd(mem_rd),
      .w_data(w_data), .a_data(a_data), .b_data(b_data),
      .mac_valid(mac_valid), .mac_weight(mac_weight), .mac_act(mac_act),
      .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out), .mac_done(mac_done),
      .lk_valid(lk_valid), .lk_x(lk_x), .lk_y(lk_y), .lk_done(lk_done),
      .rq_valid(rq_valid), .rq_acc(rq_acc), .rq_scale(rq_scale), .rq_out(rq_out),
      .rq_done(rq_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
      .busy(busy), .done(done), .err(err)
   );

   logic [7:0]  wmem [0:4095];
   logic [7:0]  amem [0:63];
   logic [31:0] bmem [0:63];

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Behavioural stand-ins for the external units.
   function automatic logic signed [31:0] leaky_ref(input logic signed [31:0] x);
      return (x < 0) ? (x >>> 3) : x;
   endfunction

   function automatic logic [7:0] rq_ref(input logic signed [31:0] x, input logic [15:0] s);
      longint p;
      p = longint'(x) * longint'({48'd0, s});
      p = p >>> 16;
      if (p > 127)  return 8'h7f;
      if (p < -128) return 8'h80;
      return p[7:0];
   endfunction

   // Stub-unit state
   int          mac_wait = 0, lk_wait = 0, rq_wait = 0;
   int          mac_lat = 0, lk_lat = 0;
   bit          mac_hang = 1'b0;
   logic [31:0] mac_res, lk_res, last_lk_x;
   logic [7:0]  rq_res;
   bit          rd_pend = 1'b0;
   int          rd_w = 0, rd_a = 0, rd_b = 0;

   // Memory and unit stubs: drive just after the rising edge, sample on the falling edge.
   initial begin : env
      int wv, av;
      w_data = '0; a_data = '0; b_data = '0;
      mac_done = 1'b0; mac_acc_out = '0; lk_done = 1'b0; lk_y = '0;
      rq_done = 1'b0; rq_out = '0;
      forever begin
         @(posedge clk); #1;
         if (rd_pend) begin
            w_data = wmem[rd_w]; a_data = amem[rd_a]; b_data = bmem[rd_b];
         end else begin
            w_data = 8'($urandom); a_data = 8'($urandom); b_data = $urandom;
         end
         mac_done = 1'b0; mac_acc_out = $urandom;
         if (mac_wait > 0) begin
            mac_wait--;
            if (mac_wait == 0) begin mac_done = 1'b1; mac_acc_out = mac_res; end
         end
         lk_done = 1'b0; lk_y = $urandom;
         if (lk_wait > 0) begin
            lk_wait--;
            if (lk_wait == 0) begin lk_done = 1'b1; lk_y = lk_res; end
         end
         rq_done = 1'b0; rq_out = 8'($urandom);
         if (rq_wait > 0) begin
            rq_wait--;
            if (rq_wait == 0) begin rq_done = 1'b1; rq_out = rq_res; end
         end
         @(negedge clk);
         rd_pend = mem_rd; rd_w = int'(w_addr); rd_a = int'(a_addr); rd_b = int'(b_addr);
         if (mac_valid) begin
            wv = $signed(mac_weight);
            av = $signed(mac_act);
            mac_res  = mac_acc_in + 32'(wv * av);
            mac_wait = mac_hang ? 0 : ((mac_lat != 0) ? mac_lat : int'($urandom_range(1, 5)));
         end
         if (lk_valid) begin
            last_lk_x = lk_x;
            lk_res    = leaky_ref(lk_x);
            lk_wait   = (lk_lat != 0) ? lk_lat : int'($urandom_range(1, 4));
         end
         if (rq_valid) begin
            rq_res  = rq_ref(rq_acc, rq_scale);
            rq_wait = int'($urandom_range(1, 4));
         end
         if (!rst_n) begin
            mac_wait = 0; lk_wait = 0; rq_wait = 0; rd_pend = 1'b0;
         end
      end
   end

   // Downstream ready: optionally random, with a forced stall on one channel.
   bit rdy_rand = 1'b0;
   int stall_ch = -1, stall_left = 0;

   initial begin : ready_drv
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (out_valid && int'(out_ch) == stall_ch && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   // Observation
   logic [7:0] obs_data [$];
   logic [5:0] obs_ch [$];
   int         obs_mac [$];
   int mac_tot = 0, mac_since = 0, rd_cnt = 0, lk_tot = 0, rq_tot = 0, done_cnt = 0;
   int multi_err = 0, idle_err = 0, hold_err = 0, stall_cyc = 0, stall_rd = 0;
   bit held = 1'b0;
   logic [7:0] held_data;
   logic [5:0] held_ch;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mac_valid) begin mac_tot++; mac_since++; end
         if (mem_rd) rd_cnt++;
         if (lk_valid) lk_tot++;
         if (rq_valid) rq_tot++;
         if (done) done_cnt++;
         if (int'(mac_valid) + int'(lk_valid) + int'(rq_valid) + int'(out_valid) > 1) multi_err++;
         if (!busy && (mac_valid || lk_valid || rq_valid || out_valid || mem_rd)) idle_err++;
         if (held && (!out_valid || out_data !== held_data || out_ch !== held_ch)) hold_err++;
         if (out_valid && !out_ready) begin
            stall_cyc++;
            if (mem_rd) stall_rd++;
         end
         held = out_valid && !out_ready && rst_n;
         held_data = out_data;
         held_ch = out_ch;
         if (out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_ch.push_back(out_ch);
            obs_mac.push_back(mac_since);
            mac_since = 0;
         end
      end
   end

   function automatic logic any_out();
      return |{busy, done, err, mem_rd, mac_valid, lk_valid, rq_valid, out_valid, w_addr,
               a_addr, b_addr, mac_weight, mac_act, mac_acc_in, lk_x, rq_acc, rq_scale,
               out_data, out_ch};
   endfunction

   task automatic clear_obs();
      obs_data.delete(); obs_ch.delete(); obs_mac.delete();
      mac_tot = 0; mac_since = 0; rd_cnt = 0; lk_tot = 0; rq_tot = 0; done_cnt = 0;
      multi_err = 0; idle_err = 0; hold_err = 0; stall_cyc = 0; stall_rd = 0;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 4096; k++) wmem[k] = 8'($urandom);
      for (int k = 0; k < 64; k++) begin amem[k] = 8'($urandom); bmem[k] = $urandom; end
   endtask

   task automatic run_pixel(input string name, input int cin, input int cout,
                            input logic [15:0] scale, input bit poke);
      logic [7:0] exp_d [$];
      logic signed [31:0] acc;
      int wv, av, budget, done_c;
      bit got_done;
      logic err0;
      for (int ch = 0; ch < cout; ch++) begin
         acc = 0;
         for (int i = 0; i < cin; i++) begin
            wv = $signed(wmem[ch * cin + i]);
            av = $signed(amem[i]);
            acc = acc + wv * av;
         end
         acc = acc + $signed(bmem[ch]);
         exp_d.push_back(rq_ref(leaky_ref(acc), scale));
      end
      clear_obs();
      @(posedge clk); #1;
      cfg_cin = 7'(cin); cfg_cout = 7'(cout); cfg_scale = scale; start = 1'b1;
      got_done = 1'b0; done_c = -1; err0 = 1'bx;
      budget = (cin + 4) * cout * 14 + 60;
      for (int c = 0; c < budget && !got_done; c++) begin
         @(posedge clk); #1;
         if (poke && c == 12) begin
            start = 1'b1; cfg_cout = 7'd9; cfg_cin = 7'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (c == 0) err0 = err;
         if (done) begin got_done = 1'b1; done_c = c; end
      end
      start = 1'b0;
      check_eq({name, ":done_seen"}, 64'(got_done), 64'd1);
      check_eq({name, ":err_cleared"}, 64'(err0), 64'd0);
      check_eq({name, ":n_out"}, 64'(obs_data.size()), 64'(cout));
      for (int k = 0; k < obs_data.size() && k < cout; k++) begin
         check_eq($sformatf("%s:data%0d", name, k), 64'(obs_data[k]), 64'(exp_d[k]));
         check_eq($sformatf("%s:ch%0d", name, k), 64'(obs_ch[k]), 64'(6'(k)));
         check_eq($sformatf("%s:macs%0d", name, k), 64'(obs_mac[k]), 64'(cin));
      end
      check_eq({name, ":mac_total"}, 64'(mac_tot), 64'(cin * cout));
      check_eq({name, ":mem_rd_total"}, 64'(rd_cnt), 64'(cout * (cin + 1)));
      check_eq({name, ":lk_total"}, 64'(lk_tot), 64'(cout));
      check_eq({name, ":rq_total"}, 64'(rq_tot), 64'(cout));
      check_eq({name, ":multi_valid"}, 64'(multi_err), 64'd0);
      check_eq({name, ":idle_valid"}, 64'(idle_err), 64'd0);
      check_eq({name, ":hold_stable"}, 64'(hold_err), 64'd0);
      check_eq({name, ":stall_rd"}, 64'(stall_rd), 64'd0);
      if (cout == 0) check_eq({name, ":done_cycle"}, 64'(done_c), 64'd0);
      @(negedge clk);
      check_eq({name, ":busy_after"}, 64'(busy), 64'd0);
      check_eq({name, ":done_once"}, 64'(done_cnt), 64'd1);
      check_eq({name, ":err_end"}, 64'(err), 64'd0);
   endtask

   initial begin : global_timeout
      #2000000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int k_err;
      bit seen;
      fill_random();
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", 64'(any_out()), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_outputs", 64'(any_out()), 64'd0);

      // Full-size pixel
      run_pixel("full64x4", 64, 4, 16'd655, 1'b0);

      // Small worked example: 3*10 + (-4)*5 + 100 = 110
      wmem[0] = 8'd3; wmem[1] = 8'hfc; amem[0] = 8'd10; amem[1] = 8'd5; bmem[0] = 32'd100;
      run_pixel("small", 2, 1, 16'd655, 1'b0);
      check_eq("small:lk_x", 64'(last_lk_x), 64'd110);
      if (obs_data.size() > 0) check_eq("small:out_is_1", 64'(obs_data[0]), 64'd1);

      // Negative path: -128 * 127
      wmem[0] = 8'h80; amem[0] = 8'h7f; bmem[0] = 32'd0;
      run_pixel("negative", 1, 1, 16'd655, 1'b0);
      check_eq("negative:lk_x", 64'(last_lk_x), 64'(32'hffffc080));
      if (obs_data.size() > 0) check_eq("negative:out", 64'(obs_data[0]), 64'(8'heb));

      // Bias wrap: 1 + 0x7fffffff
      wmem[0] = 8'd1; amem[0] = 8'd1; bmem[0] = 32'h7fffffff;
      run_pixel("wrap", 1, 1, 16'd655, 1'b0);
      check_eq("wrap:lk_x", 64'(last_lk_x), 64'(32'h80000000));

      // Backpressure on ch1 with a start pulse while busy
      fill_random();
      stall_ch = 1; stall_left = 5;
      run_pixel("backpressure", 1, 3, 16'd4000, 1'b1);
      check_eq("backpressure:stall_cycles", 64'(stall_cyc), 64'd5);
      stall_ch = -1;

      // Degenerate shapes
      run_pixel("cout0", 5, 0, 16'd655, 1'b0);
      bmem[0] = 32'd200;
      run_pixel("cin0", 0, 1, 16'd655, 1'b0);
      if (obs_data.size() > 0) check_eq("cin0:out", 64'(obs_data[0]), 64'd1);

      // MAC done on the last cycle of the wait window is still accepted
      fill_random();
      mac_lat = WaitMax;
      run_pixel("mac_lat_max", 2, 1, 16'd9000, 1'b0);
      mac_lat = 0;

      // Silent MAC: watchdog abort
      mac_hang = 1'b1;
      clear_obs();
      @(posedge clk); #1;
      cfg_cin = 7'd2; cfg_cout = 7'd2; cfg_scale = 16'd655; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (mac_valid) seen = 1'b1;
      end
      check_eq("hang:issue_seen", 64'(seen), 64'd1);
      k_err = -1;
      for (int k = 1; k <= 40 && k_err < 0; k++) begin
         @(negedge clk);
         if (err) begin
            k_err = k;
            check_eq("hang:done_with_err", 64'(done), 64'd1);
         end
      end
      check_eq("hang:err_latency", 64'(k_err), 64'(WaitMax + 1));
      repeat (3) @(negedge clk);
      check_eq("hang:err_sticky", 64'(err), 64'd1);
      check_eq("hang:busy", 64'(busy), 64'd0);
      check_eq("hang:no_output", 64'(obs_data.size()), 64'd0);
      check_eq("hang:done_once", 64'(done_cnt), 64'd1);
      mac_hang = 1'b0;
      repeat (3) @(negedge clk);
      run_pixel("after_hang", 3, 2, 16'd700, 1'b0);

      // Random pixels with random backpressure
      rdy_rand = 1'b1;
      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_pixel($sformatf("rand%0d", r), int'($urandom_range(0, 9)),
                   int'($urandom_range(1, 4)), 16'($urandom), 1'b0);
      end
      rdy_rand = 1'b0;

      // Reset while waiting on LeakyReLU
      lk_lat = 12;
      wmem[0] = 8'd7; amem[0] = 8'd9; bmem[0] = 32'd5;
      @(posedge clk); #1;
      cfg_cin = 7'd1; cfg_cout = 7'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (lk_valid) seen = 1'b1;
      end
      check_eq("rst_mid:lk_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      check_eq("rst_mid:busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid:outputs_zero", 64'(any_out()), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lk_lat = 0;
      clear_obs();
      repeat (20) @(negedge clk);
      check_eq("rst_mid:quiet_done", 64'(done_cnt), 64'd0);
      check_eq("rst_mid:quiet_rd", 64'(rd_cnt + lk_tot + rq_tot + mac_tot), 64'd0);
      check_eq("rst_mid:idle", 64'(any_out()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pw_conv_pixel_seq.md
Name: pw_conv_pixel_seq

Overview:
- Sequencer for one output pixel of a 1x1 (pointwise) convolution.
- Fetches weights, activations and biases from external synchronous ROM/RAM ports.
- Drives a shared mac_int8, then leaky_relu, then requantize (SCALE_Q=16), chaining accumulation and stages on each unit's done strobe rather than on fixed delays.
- Emits one INT8 result per output channel on a valid/ready stream; replaces hand-sequenced stimulus in layer-level benches and RTL.

Parameters:
- MAX_CIN, 64, maximum input channels; sets address width.
- MAX_COUT, 64, maximum output channels.
- WAIT_MAX, 15, maximum cycles to wait for any unit's done before abort.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin pixel; sampled only in IDLE.
- cfg_cin  in  7  input channels, 0..MAX_CIN; latched at start.
- cfg_cout  in  7  output channels, 0..MAX_COUT; latched at start.
- cfg_scale  in  16  requantize scale; latched at start.
- w_addr  out  13  weight address = ch*cin + i.
- a_addr  out  6  activation address = i.
- b_addr  out  6  bias address = ch.
- mem_rd  out  1  read strobe; data is valid the following cycle.
- w_data  in  8  signed weight.
- a_data  in  8  signed activation.
- b_data  in  32  signed bias.
- mac_valid, mac_weight[8], mac_act[8], mac_acc_in[32]  out  MAC drive.
- mac_acc_out  in  32  MAC result.
- mac_done  in  1  MAC result strobe.
- lk_valid  out  1  LeakyReLU start.
- lk_x  out  32  LeakyReLU input.
- lk_y  in  32  LeakyReLU output.
- lk_done  in  1  LeakyReLU strobe.
- rq_valid  out  1  requantize start.
- rq_acc  out  32  requantize input.
- rq_scale  out  16  requantize scale.
- rq_out  in  8  requantize output.
- rq_done  in  1  requantize strobe.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_data  out  8  signed INT8 result.
- out_ch  out  6  output channel index of out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last channel is accepted.
- err  out  1  sticky watchdog-abort flag; cleared by the next accepted start.

Behaviour:
- Reset: state IDLE. All outputs 0, including addresses, valids, busy, done and err. Internal acc, ch and i are 0. Reset asserted mid-operation aborts immediately with no further strobes.
- States: IDLE, FETCH, ISSUE, MWAIT, BFETCH, LEAKY, LWAIT, REQ, RWAIT, OUT, DONE.
- IDLE:
  - On start, latch cfg_cin, cfg_cout and cfg_scale, clear err, set ch=0, i=0, acc=0.
  - If cfg_cout==0, go to DONE; otherwise go to FETCH (or to BFETCH if cfg_cin==0).
  - start outside IDLE is ignored.
- FETCH: mem_rd=1 with addresses for (ch,i); go to ISSUE.
- ISSUE: mac_valid=1 for exactly one cycle with w_data, a_data and mac_acc_in=acc; go to MWAIT.
- MWAIT: on mac_done, acc<=mac_acc_out and i++. If i was cin-1, go to BFETCH; otherwise go to FETCH. Each MAC costs ≥3 cycles and there is no overlap of MAC ops.
- BFETCH: mem_rd=1 with b_addr=ch; go to LEAKY.
- LEAKY: lk_valid=1 for one cycle with lk_x = acc + b_data (32-bit two's-complement wrap, no saturation); go to LWAIT.
- LWAIT: on lk_done, capture lk_y and go to REQ.
- REQ: rq_valid=1 for one cycle with rq_acc = captured lk_y and rq_scale = latched scale; go to RWAIT.
- RWAIT: on rq_done, register out_data=rq_out and out_ch=ch; go to OUT.
- OUT:
  - out_valid=1, with out_data and out_ch held stable until out_ready.
  - On out_valid&&out_ready: ch++, i=0, acc=0. If ch was cout-1, go to DONE; otherwise go to FETCH (or BFETCH if cin==0).
  - out_ready high before out_valid has no effect.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Watchdog:
  - In MWAIT, LWAIT or RWAIT, a counter runs from entry.
  - If the awaited done has not arrived within WAIT_MAX cycles: err<=1, no out_valid for that channel, go directly to DONE (done still pulses).
  - A done strobe arriving in any other state is ignored.
- Only one *_valid strobe is high in any cycle; mac_valid, lk_valid and rq_valid are never high in IDLE.

Test Plan:
- cin=64, cout=4, scale=655, fixture data matching the layer7 golden hex files -> 4 outputs (ch0..3) equal to the golden expected values, in order, then a done pulse, with exactly 64 mac_valid pulses per channel.
- cin=2, cout=1, w={3,-4}, a={10,5}, bias=100 -> lk_x=110. With the requantize model, out_data = sat((110*655)>>16) = 1, out_ch=0.
- Negative path, cin=1, w=-128, a=127, bias=0 -> lk_x=-16256, leaky scaling applied, output matches the golden model. Also drive bias=0x7FFFFFFF with acc=1 -> lk_x wraps to 0x80000000.
- Backpressure, cin=1, cout=3, out_ready low for 5 cycles on ch1 -> out_valid and out_data held stable, no mem_rd while stalled, ch2 follows after accept. A start pulse during busy is ignored.
- cout=0 -> done the cycle after DONE entry with no strobes. cin=0, bias=200 -> out_data = requant(leaky(200)) with zero mac_valid.
- A stub MAC that never asserts done -> err=1 after WAIT_MAX+1 cycles, done pulses, next start clears err. Separately, assert rst_n=0 in LWAIT -> all outputs 0 immediately.
